fifo_cdc_core: RTL and testbench

Byte-stream FIFO in the receive path, between the MAC receive byte output (`rxData`/`rxDataValid`) and downstream parsing logic. The write side pushes bytes; the read side drains automatically, one byte per cycle, whenever data is visible. It keeps the gray-coded, pointer-synchronized structure of a CDC FIFO on a single clock, so read-side latency matches the clock-crossing version. A parameter trades one synchronizer stage for lower latency.

---
 rtl/fifo_cdc_core.sv | 122 ++++++++++++
 tb/tb_fifo_cdc_core.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_cdc_core.sv
// rtl/fifo_cdc_core.sv - single-clock byte FIFO with gray-coded, synchronized write pointer
// Optional sticky overflow flag: define FIFO_CDC_OVERFLOW_FLAG_EN.
module fifo_cdc_core #(
    parameter bit XPERIMENTAL_LOW_LAT_CDC = 1'b0,
    parameter int DATA_WIDTH              = 8,
    parameter int ADDR_WIDTH              = 4
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  wrEnIn,
    input  logic [DATA_WIDTH-1:0] wrDataIn,
    output logic [DATA_WIDTH-1:0] rdDataOut,
    output logic                  rdDataValidOut,
    output logic                  fullOut,
`ifdef FIFO_CDC_OVERFLOW_FLAG_EN
    output logic                  emptyOut,
    output logic                  overflowOut
`else
    output logic                  emptyOut
`endif
);
    localparam int DEPTH       = 1 << ADDR_WIDTH;
    localparam int PW          = ADDR_WIDTH + 1;
    localparam int SYNC_STAGES = XPERIMENTAL_LOW_LAT_CDC ? 1 : 2;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         sync_q [SYNC_STAGES];
    logic [PW-1:0]         wr_ptr_sync;
    logic [PW-1:0]         occupancy;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  full;
    logic                  wr_fire;
    logic                  rd_fire;

    // Full uses the live read pointer; empty only sees the synchronized write pointer.
    assign occupancy   = wr_ptr_q - rd_ptr_q;
    assign full        = (occupancy == PW'(DEPTH));
    assign wr_ptr_sync = gray2bin(sync_q[SYNC_STAGES-1]);
    assign wr_fire     = wrEnIn && !full;
    assign rd_fire     = (wr_ptr_sync != rd_ptr_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn && wr_fire) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wrDataIn;
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            sync_q[0] <= bin2gray(wr_ptr_q);
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            end
        end
    end

`ifdef FIFO_CDC_OVERFLOW_FLAG_EN
    logic overflow_q;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            overflow_q <= 1'b0;
        end else if (wrEnIn && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflowOut = overflow_q;
`endif

    assign rdDataOut      = rd_data_q;
    assign rdDataValidOut = rd_valid_q;
    assign fullOut        = full;
    assign emptyOut       = !rd_fire;
endmodule

// File: tb/tb_fifo_cdc_core.sv
// tb/tb_fifo_cdc_core.sv - directed bench driving low-latency and standard instances in parallel
module tb_fifo_cdc_core;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] d_lo, d_std;
    logic       v_lo, v_std, full_lo, full_std, empty_lo, empty_std;
`ifdef FIFO_CDC_OVERFLOW_FLAG_EN
    logic       ovf_lo, ovf_std;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int qd_lo[$], qc_lo[$], qd_std[$], qc_std[$];
    int exp_q[$];
    bit full_seen;
    int first;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_cdc_core #(.XPERIMENTAL_LOW_LAT_CDC(1'b1), .DATA_WIDTH(8), .ADDR_WIDTH(4)) u_lo (
        .clkIn(clk), .rstIn(rst), .wrEnIn(wr), .wrDataIn(wdata),
        .rdDataOut(d_lo), .rdDataValidOut(v_lo), .fullOut(full_lo),
`ifdef FIFO_CDC_OVERFLOW_FLAG_EN
        .emptyOut(empty_lo), .overflowOut(ovf_lo)
`else
        .emptyOut(empty_lo)
`endif
    );

    fifo_cdc_core #(.XPERIMENTAL_LOW_LAT_CDC(1'b0), .DATA_WIDTH(8), .ADDR_WIDTH(4)) u_std (
        .clkIn(clk), .rstIn(rst), .wrEnIn(wr), .wrDataIn(wdata),
        .rdDataOut(d_std), .rdDataValidOut(v_std), .fullOut(full_std),
`ifdef FIFO_CDC_OVERFLOW_FLAG_EN
        .emptyOut(empty_std), .overflowOut(ovf_std)
`else
        .emptyOut(empty_std)
`endif
    );

    always @(negedge clk) begin
        if (v_lo === 1'b1) begin
            qd_lo.push_back(int'(d_lo));
            qc_lo.push_back(cyc);
        end
        if (v_std === 1'b1) begin
            qd_std.push_back(int'(d_std));
            qc_std.push_back(cyc);
        end
        if (full_lo === 1'b1 || full_std === 1'b1) full_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_stream(input string tag, input int got[$], input int exp[$]);
        int bad;
        bad = 0;
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i >= got.size() || got[i] != exp[i]) bad++;
        end
        check({tag, "_order"}, bad, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        qd_lo.delete(); qc_lo.delete(); qd_std.delete(); qc_std.delete();
        exp_q.delete();
        full_seen = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr = 1'b1; wdata = 8'h55;
        // Reset held with writes requested
        repeat (3) begin
            @(negedge clk);
            check("rst_valid_lo", v_lo, 1'b0);
            check("rst_valid_std", v_std, 1'b0);
            check("rst_data_lo", d_lo, 8'h00);
            check("rst_empty_lo", empty_lo, 1'b1);
            check("rst_empty_std", empty_std, 1'b1);
            check("rst_full_lo", full_lo, 1'b0);
        end
        step();
        rst = 1'b0; wr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_valid_lo", v_lo, 1'b0);
            check("post_rst_valid_std", v_std, 1'b0);
            check("post_rst_data_std", d_std, 8'h00);
            check("post_rst_empty_lo", empty_lo, 1'b1);
            check("post_rst_empty_std", empty_std, 1'b1);
        end
`ifdef FIFO_CDC_OVERFLOW_FLAG_EN
        check("rst_ovf_lo", ovf_lo, 1'b0);
`endif

        // 500-byte continuous stream
        clear_mon();
        step();
        first = cyc + 1;
        for (int i = 0; i < 500; i++) begin
            wr = 1'b1; wdata = 8'(i);
            exp_q.push_back(i & 8'hFF);
            step();
        end
        wr = 1'b0;
        repeat (8) step();
        cmp_stream("stream_lo", qd_lo, exp_q);
        cmp_stream("stream_std", qd_std, exp_q);
        if (qc_lo.size() == 500 && qc_std.size() == 500) begin
            check("stream_lat_lo", qc_lo[0] - first, 2);
            check("stream_lat_std", qc_std[0] - first, 3);
            check("stream_cont_lo", qc_lo[499] - qc_lo[0], 499);
            check("stream_cont_std", qc_std[499] - qc_std[0], 499);
        end else begin
            check("stream_timing_lengths", qc_lo.size() + qc_std.size(), 1000);
        end
        check("stream_full", full_seen, 1'b0);

        // Single write: exact per-edge behaviour
        clear_mon();
        step();
        wr = 1'b1; wdata = 8'hA5;
        step();
        wr = 1'b0;
        @(negedge clk);
        check("single_e0_valid_lo", v_lo, 1'b0);
        check("single_e0_empty_lo", empty_lo, 1'b1);
        check("single_e0_empty_std", empty_std, 1'b1);
        @(negedge clk);
        check("single_e1_empty_lo", empty_lo, 1'b0);
        check("single_e1_empty_std", empty_std, 1'b1);
        check("single_e1_valid_lo", v_lo, 1'b0);
        @(negedge clk);
        check("single_e2_valid_lo", v_lo, 1'b1);
        check("single_e2_data_lo", d_lo, 8'hA5);
        check("single_e2_empty_lo", empty_lo, 1'b1);
        check("single_e2_empty_std", empty_std, 1'b0);
        check("single_e2_valid_std", v_std, 1'b0);
        @(negedge clk);
        check("single_e3_valid_std", v_std, 1'b1);
        check("single_e3_data_std", d_std, 8'hA5);
        check("single_e3_valid_lo", v_lo, 1'b0);
        repeat (3) @(negedge clk);
        check("single_hold_valid_lo", v_lo, 1'b0);
        check("single_hold_valid_std", v_std, 1'b0);
        check("single_hold_data_lo", d_lo, 8'hA5);
        check("single_hold_data_std", d_std, 8'hA5);
        check("single_pulses_lo", qd_lo.size(), 1);
        check("single_pulses_std", qd_std.size(), 1);

        // 20-byte burst
        clear_mon();
        step();
        for (int i = 0; i < 20; i++) begin
            wr = 1'b1; wdata = 8'hC0 + 8'(i);
            exp_q.push_back(8'hC0 + i);
            step();
        end
        wr = 1'b0;
        repeat (8) step();
        cmp_stream("burst_lo", qd_lo, exp_q);
        cmp_stream("burst_std", qd_std, exp_q);
        check("burst_full", full_seen, 1'b0);
`ifdef FIFO_CDC_OVERFLOW_FLAG_EN
        check("burst_ovf_lo", ovf_lo, 1'b0);
        check("burst_ovf_std", ovf_std, 1'b0);
`endif

        // Burst cut by a reset pulse: queued bytes are discarded
        clear_mon();
        step();
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; wdata = 8'h30 + 8'(i);
            step();
        end
        rst = 1'b1; wr = 1'b1; wdata = 8'h35;
        step();
        rst = 1'b0; wr = 1'b0;
        repeat (8) step();
        exp_q = '{32'h30, 32'h31, 32'h32};
        cmp_stream("midrst_lo", qd_lo, exp_q);
        exp_q = '{32'h30, 32'h31};
        cmp_stream("midrst_std", qd_std, exp_q);
        @(negedge clk);
        check("midrst_empty_lo", empty_lo, 1'b1);
        check("midrst_empty_std", empty_std, 1'b1);
        check("midrst_data_lo", d_lo, 8'h00);
        check("midrst_data_std", d_std, 8'h00);

        // Gapped writes across several pointer wraps
        clear_mon();
        step();
        for (int i = 0; i < 40; i++) begin
            wr = 1'b1; wdata = 8'h40 + 8'(i);
            exp_q.push_back(8'h40 + i);
            step();
            if (i % 7 == 6) begin
                wr = 1'b0;
                repeat (2) step();
            end
        end
        wr = 1'b0;
        repeat (8) step();
        cmp_stream("wrap_lo", qd_lo, exp_q);
        cmp_stream("wrap_std", qd_std, exp_q);
        check("wrap_full", full_seen, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
